input_req_ctrl: RTL and testbench

Per-input-port request controller for the shared-cache switch. It queues packet descriptors (destination output port, cache base address, length) written by the ingress side. It raises a one-hot request toward the destination output port's weighted round-robin arbiter and waits for that arbiter's grant. While granted, it streams the packet's cache read addresses one beat per cycle. It is the requesting end of the output arbitration interface: one instance per input port, with its `req_out[j]` wired into bit NUB of output j's arbiter request vector.

---
 rtl/input_req_ctrl_if.sv | 39 +++
 rtl/input_req_ctrl.sv | 137 +++++++++++++
 tb/tb_input_req_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/input_req_ctrl_if.sv
// Bundle between one input port's ingress/arbitration/cache-read logic and its
// request controller. The controller attaches to the slave modport.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

interface input_req_ctrl_if #(
    parameter int PORT_NUB = `PORT_NUB_TOTAL,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 4
);
    localparam int WIDTH_OUT = $clog2(PORT_NUB);

    logic                 desc_valid;
    logic                 desc_ready;
    logic [WIDTH_OUT-1:0] desc_dest;
    logic [ADDR_W-1:0]    desc_addr;
    logic [LEN_W-1:0]     desc_len;
    logic [PORT_NUB-1:0]  req_out;
    logic [PORT_NUB-1:0]  grant_in;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [WIDTH_OUT-1:0] rd_port;
    logic                 rd_last;
    logic                 err_self;
    logic                 err_grant;

    modport master (
        output desc_valid, desc_dest, desc_addr, desc_len, grant_in,
        input  desc_ready, req_out, rd_en, rd_addr, rd_port, rd_last,
               err_self, err_grant
    );

    modport slave (
        input  desc_valid, desc_dest, desc_addr, desc_len, grant_in,
        output desc_ready, req_out, rd_en, rd_addr, rd_port, rd_last,
               err_self, err_grant
    );
endinterface

// File: rtl/input_req_ctrl.sv
// Per-input-port request controller: queues packet descriptors, requests the
// destination output arbiter and streams cache read addresses while granted.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module input_req_ctrl #(
    parameter int NUB      = 0,
    parameter int PORT_NUB = `PORT_NUB_TOTAL,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 4
) (
    input logic             clk,
    input logic             rst_n,
    input_req_ctrl_if.slave bus
);
    localparam int WIDTH_OUT = $clog2(PORT_NUB);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic {IDLE, BUSY} state_e;

    typedef struct packed {
        logic [WIDTH_OUT-1:0] dest;
        logic [ADDR_W-1:0]    addr;
        logic [LEN_W-1:0]     len;
    } desc_t;

    desc_t                fifo_mem [DEPTH];
    desc_t                in_desc;
    desc_t                head;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    state_e               state_q, state_d;
    logic [WIDTH_OUT-1:0] cur_dest_q, cur_dest_d;
    logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]     beats_left_q, beats_left_d;
    logic                 err_self_q, err_self_d;
    logic                 push_hs, push, pop, beat, last_beat, fifo_empty;
    logic [PORT_NUB-1:0]  req_vec;

    assign in_desc    = '{dest: bus.desc_dest, addr: bus.desc_addr, len: bus.desc_len};
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);

    // Readiness looks at occupancy only, so a same-cycle pop never frees a slot.
    assign bus.desc_ready = (count_q != CNT_W'(DEPTH));
    assign push_hs        = bus.desc_valid && bus.desc_ready;
    assign push           = push_hs && (bus.desc_dest != WIDTH_OUT'(NUB));
    assign err_self_d     = push_hs && (bus.desc_dest == WIDTH_OUT'(NUB));

    assign beat      = (state_q == BUSY) && bus.grant_in[cur_dest_q];
    assign last_beat = beat && (beats_left_q == '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cur_dest_d   = cur_dest_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        pop          = 1'b0;
        req_vec      = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    state_d      = BUSY;
                    cur_dest_d   = head.dest;
                    cur_addr_d   = head.addr;
                    beats_left_d = head.len;
                end
            end
            BUSY: begin
                req_vec = PORT_NUB'(1) << cur_dest_q;
                if (beat) begin
                    cur_addr_d   = cur_addr_q + ADDR_W'(1);
                    beats_left_d = beats_left_q - LEN_W'(1);
                    // Chain straight into the next packet to avoid an idle cycle.
                    if (last_beat) begin
                        if (!fifo_empty) begin
                            pop          = 1'b1;
                            cur_dest_d   = head.dest;
                            cur_addr_d   = head.addr;
                            beats_left_d = head.len;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    assign bus.req_out   = req_vec;
    assign bus.rd_en     = beat;
    assign bus.rd_last   = last_beat;
    assign bus.rd_addr   = cur_addr_q;
    assign bus.rd_port   = cur_dest_q;
    assign bus.err_self  = err_self_q;
    assign bus.err_grant = (state_q == IDLE) ? (|bus.grant_in)
                                             : (|(bus.grant_in & ~req_vec));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cur_dest_q   <= '0;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            err_self_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cur_dest_q   <= cur_dest_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            err_self_q   <= err_self_d;
        end
    end

    // NOTE: descriptor storage is not reset; occupancy alone says which slots are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_desc;
    end
endmodule

// File: tb/tb_input_req_ctrl.sv
// Self-checking bench for input_req_ctrl: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based packet model.
module tb_input_req_ctrl;
    localparam int NUB      = 0;
    localparam int PORT_NUB = 4;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 10;
    localparam int LEN_W    = 4;

    typedef struct {
        logic [1:0]        dest;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cmp_cnt  = 0;
    int   fail_cnt = 0;

    // Reference model: pending packets plus the one currently being served.
    pkt_t              q[$];
    logic              cur_valid;
    logic [1:0]        cur_dest;
    logic [ADDR_W-1:0] cur_addr;
    int                cur_rem;
    logic              exp_err_self;

    always #5 clk = ~clk;

    input_req_ctrl_if #(.PORT_NUB(PORT_NUB), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    input_req_ctrl #(
        .NUB(NUB), .PORT_NUB(PORT_NUB), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur_valid    = 1'b0;
        cur_dest     = '0;
        cur_addr     = '0;
        cur_rem      = 0;
        exp_err_self = 1'b0;
    endtask

    task automatic model_load();
        pkt_t h;
        h         = q.pop_front();
        cur_valid = 1'b1;
        cur_dest  = h.dest;
        cur_addr  = h.addr;
        cur_rem   = int'(h.len) + 1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},       32'(bus.req_out),    32'h0);
        check({tag, "_rd_en"},     32'(bus.rd_en),      32'h0);
        check({tag, "_rd_last"},   32'(bus.rd_last),    32'h0);
        check({tag, "_rd_addr"},   32'(bus.rd_addr),    32'h0);
        check({tag, "_rd_port"},   32'(bus.rd_port),    32'h0);
        check({tag, "_err_self"},  32'(bus.err_self),   32'h0);
        check({tag, "_err_grant"}, 32'(bus.err_grant),  32'h0);
        check({tag, "_ready"},     32'(bus.desc_ready), 32'h1);
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input logic v, input logic [1:0] d, input logic [ADDR_W-1:0] a,
                         input logic [LEN_W-1:0] l, input logic [3:0] g);
        logic [3:0] exp_req;
        logic       exp_en, exp_last, exp_err_g, exp_ready, acc;
        bus.desc_valid = v;
        bus.desc_dest  = d;
        bus.desc_addr  = a;
        bus.desc_len   = l;
        bus.grant_in   = g;
        exp_req   = cur_valid ? (4'b0001 << cur_dest) : 4'b0000;
        exp_en    = cur_valid && g[cur_dest];
        exp_last  = exp_en && (cur_rem == 1);
        exp_err_g = |(g & ~exp_req);
        exp_ready = (q.size() < DEPTH);
        @(negedge clk);
        check("req_out",    32'(bus.req_out),    32'(exp_req));
        check("rd_en",      32'(bus.rd_en),      32'(exp_en));
        check("rd_last",    32'(bus.rd_last),    32'(exp_last));
        check("desc_ready", 32'(bus.desc_ready), 32'(exp_ready));
        check("err_grant",  32'(bus.err_grant),  32'(exp_err_g));
        check("err_self",   32'(bus.err_self),   32'(exp_err_self));
        if (exp_en) begin
            check("rd_addr", 32'(bus.rd_addr), 32'(cur_addr));
            check("rd_port", 32'(bus.rd_port), 32'(cur_dest));
        end
        @(posedge clk);
        acc = v && exp_ready;
        if (!cur_valid) begin
            if (q.size() > 0) model_load();
        end else if (exp_en) begin
            cur_addr = cur_addr + 1'b1;
            cur_rem--;
            if (cur_rem == 0) begin
                if (q.size() > 0) model_load();
                else cur_valid = 1'b0;
            end
        end
        if (acc && d != 2'(NUB)) q.push_back('{dest: d, addr: a, len: l});
        exp_err_self = acc && (d == 2'(NUB));
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic [3:0] g);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, '0, g);
    endtask

    initial begin
        logic [1:0]        rd;
        logic [ADDR_W-1:0] ra;
        logic [LEN_W-1:0]  rl;
        logic [3:0]        rg;
        logic              rv;

        rst_n          = 1'b0;
        bus.desc_valid = 1'b0;
        bus.desc_dest  = '0;
        bus.desc_addr  = '0;
        bus.desc_len   = '0;
        bus.grant_in   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Single packet with a steady grant.
        cycle(1'b1, 2'd2, 10'h010, 4'd2, 4'b0100);
        idle_cycles(6, 4'b0100);

        // Same packet with a toggling grant.
        cycle(1'b1, 2'd2, 10'h010, 4'd2, 4'b0000);
        for (int i = 0; i < 10; i++) cycle(1'b0, 2'd0, '0, '0, (i % 2 == 0) ? 4'b0100 : 4'b0000);

        // Fill the queue without grants, then free one slot with desc_valid held.
        for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, 2'd1, 10'(i * 16), 4'd0, 4'b0000);
        cycle(1'b1, 2'd1, 10'h3A0, 4'd0, 4'b0010);
        cycle(1'b1, 2'd1, 10'h3B0, 4'd0, 4'b0000);
        idle_cycles(DEPTH + 4, 4'b0010);

        // Back-to-back packets to different outputs.
        cycle(1'b1, 2'd1, 10'h100, 4'd0, 4'b0000);
        cycle(1'b1, 2'd3, 10'h200, 4'd1, 4'b0000);
        idle_cycles(6, 4'b1010);

        // Self-addressed descriptor, then an address wrap.
        cycle(1'b1, 2'(NUB), 10'h055, 4'd3, 4'b0000);
        idle_cycles(3, 4'b0000);
        cycle(1'b1, 2'd3, 10'h3FF, 4'd1, 4'b1000);
        idle_cycles(5, 4'b1000);

        // Reset in the middle of a packet.
        cycle(1'b1, 2'd2, 10'h080, 4'd7, 4'b0100);
        idle_cycles(3, 4'b0100);
        #2;
        rst_n          = 1'b0;
        bus.desc_valid = 1'b0;
        bus.grant_in   = '0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(5, 4'b0100);

        // Random traffic, including self-addressed descriptors and stray grants.
        for (int i = 0; i < 600; i++) begin
            rv = 1'($urandom_range(1));
            rd = 2'($urandom_range(3));
            ra = 10'($urandom_range(1023));
            rl = 4'($urandom_range(3));
            rg = '0;
            if (cur_valid && $urandom_range(3) != 0) rg[cur_dest] = 1'b1;
            if ($urandom_range(15) == 0) rg[2'($urandom_range(3))] = 1'b1;
            cycle(rv, rd, ra, rl, rg);
        end
        idle_cycles(80, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule
